// File: rtl/jk_flip_flop_dff.sv
// jk_flip_flop_dff: a vector of WIDTH independent edge-triggered JK flip-flops.
// Each bit is a D flop whose next state is D = (J & ~Q) | (~K & Q).
// The reset_async input is a synchronous, active-high reset; the name is
// historical and kept for compatibility with existing instantiations.
// Optional feature macro: FFJK_QBAR_EN adds output Qn = ~Q, driven from the
// same register with no extra flop.
module jk_flip_flop_dff #(
  parameter int unsigned      WIDTH       = 1,
  parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             reset_async,
  input  logic [WIDTH-1:0] J,
  input  logic [WIDTH-1:0] K,
`ifdef FFJK_QBAR_EN
  output logic [WIDTH-1:0] Qn,
`endif
  output logic [WIDTH-1:0] Q
);

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;

  // JK characteristic equation per bit; reset priority is applied here so the
  // flop itself is a plain D register.
  always_comb begin
    q_d = q_q;
    if (reset_async) begin
      q_d = RESET_VALUE;
    end else begin
      q_d = (J & ~q_q) | (~K & q_q);
    end
  end

  // State register, updated on the rising edge only.
  always_ff @(posedge clk) begin
    q_q <= q_d;
  end

  assign Q = q_q;

`ifdef FFJK_QBAR_EN
  // Complement output comes straight off the same register.
  assign Qn = ~q_q;
`endif

endmodule

// File: tb/tb_jk_flip_flop_dff.sv
// Directed bench for jk_flip_flop_dff: one WIDTH=1 instance with default reset
// value and one WIDTH=4 instance with a non-zero reset value.
module tb_jk_flip_flop_dff;

  logic       clk;
  logic       reset_async;
  logic       j1, k1;
  logic [3:0] j4, k4;
  logic       q1;
  logic [3:0] q4;
`ifdef FFJK_QBAR_EN
  logic       qn1;
  logic [3:0] qn4;
`endif

  int tests;
  int fails;

  jk_flip_flop_dff u_dut1 (
    .clk         (clk),
    .reset_async (reset_async),
    .J           (j1),
    .K           (k1),
`ifdef FFJK_QBAR_EN
    .Qn          (qn1),
`endif
    .Q           (q1)
  );

  jk_flip_flop_dff #(
    .WIDTH       (4),
    .RESET_VALUE (4'b1010)
  ) u_dut4 (
    .clk         (clk),
    .reset_async (reset_async),
    .J           (j4),
    .K           (k4),
`ifdef FFJK_QBAR_EN
    .Qn          (qn4),
`endif
    .Q           (q4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Check both instances (and complements when present).
  task automatic check_state(input string tag, input logic e1, input logic [3:0] e4);
    check({tag, "/q1"}, {3'b000, q1}, {3'b000, e1});
    check({tag, "/q4"}, q4, e4);
`ifdef FFJK_QBAR_EN
    check({tag, "/qn1"}, {3'b000, qn1}, {3'b000, ~e1});
    check({tag, "/qn4"}, qn4, ~e4);
`endif
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Truth-table reference for one JK bit.
  function automatic logic jk_ref(input logic j, input logic k, input logic q);
    case ({j, k})
      2'b00:   jk_ref = q;
      2'b01:   jk_ref = 1'b0;
      2'b10:   jk_ref = 1'b1;
      default: jk_ref = ~q;
    endcase
  endfunction

  logic       m1;
  logic [3:0] m4;

  initial begin
    tests = 0;
    fails = 0;
    reset_async = 1'b1;
    j1 = 1'b1; k1 = 1'b1;
    j4 = 4'b1111; k4 = 4'b1111;

    // Reset wins over JK=11.
    step();
    check_state("reset_jk11", 1'b0, 4'b1010);

    // Reset held for 3 edges with JK=10.
    j1 = 1'b1; k1 = 1'b0;
    j4 = 4'b1111; k4 = 4'b0000;
    for (int i = 0; i < 3; i++) begin
      step();
      check_state("reset_hold", 1'b0, 4'b1010);
    end

    // Release: set on dut1; mixed hold/clear/set/toggle on dut4 bits 3..0.
    reset_async = 1'b0;
    j1 = 1'b1; k1 = 1'b0;
    j4 = 4'b0011; k4 = 4'b0101;
    step();
    check_state("set_mixed", 1'b1, 4'b1011);

    j1 = 1'b0; k1 = 1'b1;
    step();
    check_state("clear_mixed", 1'b0, 4'b1010);

    // Hold with Q=1.
    j1 = 1'b1; k1 = 1'b0;
    j4 = 4'b0000; k4 = 4'b0000;
    step();
    check_state("set_again", 1'b1, 4'b1010);
    j1 = 1'b0; k1 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check_state("hold_one", 1'b1, 4'b1010);
    end

    // Glitch on J/K between edges is ignored.
    #2;
    j1 = 1'b0; k1 = 1'b1;
    j4 = 4'b1111; k4 = 4'b1111;
    #2;
    j1 = 1'b0; k1 = 1'b0;
    j4 = 4'b0000; k4 = 4'b0000;
    step();
    check_state("glitch_ignored", 1'b1, 4'b1010);

    // Hold with Q=0.
    j1 = 1'b0; k1 = 1'b1;
    step();
    check_state("clear_again", 1'b0, 4'b1010);
    j1 = 1'b0; k1 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check_state("hold_zero", 1'b0, 4'b1010);
    end

    // Toggle for 4 edges.
    j1 = 1'b1; k1 = 1'b1;
    j4 = 4'b1111; k4 = 4'b1111;
    step(); check_state("toggle1", 1'b1, 4'b0101);
    step(); check_state("toggle2", 1'b0, 4'b1010);
    step(); check_state("toggle3", 1'b1, 4'b0101);
    step(); check_state("toggle4", 1'b0, 4'b1010);

    // Reset asserted mid-cycle takes effect only at the edge.
    step();
    check_state("toggle5", 1'b1, 4'b0101);
    #2;
    reset_async = 1'b1;
    #1;
    check_state("reset_between_edges", 1'b1, 4'b0101);
    step();
    check_state("reset_mid_op", 1'b0, 4'b1010);
    reset_async = 1'b0;
    step();
    check_state("toggle_resume", 1'b1, 4'b0101);

    // Random JK for 20 edges against the truth-table model.
    m1 = 1'b1;
    m4 = 4'b0101;
    for (int n = 0; n < 20; n++) begin
      j1 = 1'($urandom_range(0, 1));
      k1 = 1'($urandom_range(0, 1));
      j4 = 4'($urandom_range(0, 15));
      k4 = 4'($urandom_range(0, 15));
      m1 = jk_ref(j1, k1, m1);
      for (int b = 0; b < 4; b++) begin
        m4[b] = jk_ref(j4[b], k4[b], m4[b]);
      end
      step();
      check_state("random", m1, m4);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/jk_flip_flop_dff.md
Name: jk_flip_flop_dff

Overview:
- Vector of edge-triggered JK flip-flops. Each bit is built from one D flip-flop plus next-state gating: D = (J & ~Q) | (~K & Q).
- General-purpose storage and toggle element for sequential datapaths and counters in the Mano-style sequential library.
- With the default WIDTH = 1 it is a single JK flip-flop.

Parameters:
- WIDTH, 1, number of independent JK bits (all share clk and reset_async).
- RESET_VALUE, {WIDTH{1'b0}}, value loaded into Q on reset.

Ports:
- clk  input  1  rising-edge clock.
- reset_async  input  1  reset, synchronous, active-high. The name is kept for codebase compatibility; it is NOT asynchronous.
- J  input  WIDTH  per-bit set/toggle request.
- K  input  WIDTH  per-bit reset/toggle request.
- Q  output  WIDTH  registered state.

Behaviour:
- One clock; all state changes on the rising edge of clk only. No combinational path from J or K to Q.
- Reset: if reset_async = 1 at a rising edge, Q <= RESET_VALUE regardless of J and K. Reset has priority over every JK combination.
- While reset_async stays high across edges, Q holds RESET_VALUE.
- Reset asserted or deasserted between edges has no effect until the next edge.
- Normal operation, per bit i at each rising edge with reset_async = 0:
  - JK = 00: hold, Q[i] <= Q[i].
  - JK = 01: clear, Q[i] <= 0.
  - JK = 10: set, Q[i] <= 1.
  - JK = 11: toggle, Q[i] <= ~Q[i].
- Structure: next-state D[i] = (J[i] & ~Q[i]) | (~K[i] & Q[i]), computed combinationally from current Q. A D register with synchronous reset mux then captures it.
- Latency: a JK change sampled at edge n is visible on Q immediately after edge n (1-cycle registered).
- Bits are fully independent; no cross-bit interaction.
- Inputs are sampled only at edges. J/K glitches between edges are ignored.
- X/Z on J or K is outside the contract; reset always resolves Q to a known value.
- Power-up before the first reset edge: Q is undefined; the bench must apply reset first.

Optional Feature:
- Macro FFJK_QBAR_EN.
- Defined: an extra output port Qn (output, WIDTH) is present and equals ~Q at all times. It is driven from the same register, with no separate flop. On reset, Qn = ~RESET_VALUE.
- Not defined: the Qn port does not exist. All other behaviour is identical.

Test Plan:
- Reset: reset_async = 1 for one edge with J = 1, K = 1 -> Q = 0 after the edge. Hold reset for 3 edges with JK = 10 -> Q stays 0.
- Set/clear: reset released, JK = 10 -> Q = 1 after the next edge. JK = 01 -> Q = 0 after the following edge.
- Hold: Q = 1, JK = 00 for 3 edges -> Q stays 1. Repeat with Q = 0 -> stays 0.
- Toggle: from Q = 0, JK = 11 for 4 edges -> Q sequence 1, 0, 1, 0.
- Reset mid-operation: toggling with JK = 11, assert reset_async between edges -> Q unchanged until the edge, then 0. Deassert -> toggling resumes from 0 (next Q = 1).
- Randomized check: 20 cycles of random JK with WIDTH = 4, checked per bit against the JK truth table using Q sampled before each edge. With FFJK_QBAR_EN defined, Qn == ~Q is checked at every edge.
